// File: rtl/request_arbiter.sv
// request_arbiter: 4-way round-robin arbiter with ack/drop/timeout release.
// A grant is held until the holder acks, drops its request, or TIMEOUT
// cycles elapse; every grant is followed by a one-cycle RELEASE gap.
// Ports:
//   clk     - clock, all state updates on rising edge
//   rst     - synchronous active-high reset
//   req     - [3:0] level-sensitive request lines
//   ack     - grant holder done (only sampled in GRANT)
//   grant   - [3:0] registered one-hot grant (or 0000)
//   enable  - registered, high exactly when grant is non-zero
//   timeout - registered one-cycle pulse on forced release
//   busy    - registered, high whenever the FSM is not IDLE
module request_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ack,
  output logic [3:0] grant,
  output logic       enable,
  output logic       timeout,
  output logic       busy
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               enable_q, enable_d;
  logic               timeout_q, timeout_d;
  logic               busy_q, busy_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               hold_expired;

  // Round-robin search: first set req bit starting at last+1, wrapping.
  always_comb begin : pick_search
    logic [IDX_W-1:0] cand;
    pick_found = 1'b0;
    pick_idx   = last_q;
    cand       = last_q;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = last_q + IDX_W'(i);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Counter value on the last cycle the grant may be visible.
  assign hold_expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick_found) begin
          state_d = GRANT;
          grant_d = N_REQ'(1) << pick_idx;
          idx_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        // Release priority: ack, then request drop, then timeout.
        if (ack || !req[idx_q] || hold_expired) begin
          state_d   = RELEASE;
          grant_d   = '0;
          last_d    = idx_q;
          cnt_d     = '0;
          timeout_d = !ack && req[idx_q];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase

    enable_d = |grant_d;
    busy_d   = (state_d != IDLE);
  end

  // State and output registers; reset restores round-robin start at req[0].
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      enable_q  <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      last_q    <= IDX_W'(3);
      idx_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      enable_q  <= enable_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant   = grant_q;
  assign enable  = enable_q;
  assign timeout = timeout_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_request_arbiter.sv
// Scoreboard bench for request_arbiter: stimulus process runs a reference
// model and queues expected outputs; a monitor pops and compares each cycle.
module tb_request_arbiter;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic [3:0] grant;
  logic       enable;
  logic       timeout;
  logic       busy;

  request_arbiter #(.TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ack     (ack),
    .grant   (grant),
    .enable  (enable),
    .timeout (timeout),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic       en;
    logic       to;
    logic       bz;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: phase 0 = no owner, 1 = owner holds, 2 = gap cycle.
  int   m_phase = 0;
  int   m_last  = 3;
  int   m_owner = 0;
  int   m_seen  = 0;   // cycles the current grant has been visible
  logic m_to    = 1'b0;

  task automatic model_step(input logic r, input logic [3:0] rq, input logic a);
    m_to = 1'b0;
    if (r) begin
      m_phase = 0;
      m_last  = 3;
      m_seen  = 0;
    end else if (m_phase == 0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (m_phase == 0 && rq[c]) begin
          m_phase = 1;
          m_owner = c;
          m_seen  = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (a) begin
        m_phase = 2;
        m_last  = m_owner;
      end else if (!rq[m_owner]) begin
        m_phase = 2;
        m_last  = m_owner;
      end else if (m_seen == TO) begin
        m_phase = 2;
        m_last  = m_owner;
        m_to    = 1'b1;
      end else begin
        m_seen++;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  // One clock of stimulus: drive, predict post-edge outputs, queue them.
  task automatic cyc(input logic r, input logic [3:0] rq, input logic a);
    exp_t e;
    rst = r;
    req = rq;
    ack = a;
    model_step(r, rq, a);
    e.g  = (m_phase == 1) ? (4'b0001 << m_owner) : 4'b0000;
    e.en = (m_phase == 1);
    e.to = m_to;
    e.bz = (m_phase != 0);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, want);
    end
  endtask

  // Monitor: every cycle the DUT presents registered outputs; compare them.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("grant",   grant,          e.g);
        chk("enable",  {3'b0, enable}, {3'b0, e.en});
        chk("timeout", {3'b0, timeout},{3'b0, e.to});
        chk("busy",    {3'b0, busy},   {3'b0, e.bz});
        chk("onehot",  {3'b0, ($countones(grant) <= 1)}, 4'b0001);
        chk("en_eq_or",{3'b0, enable}, {3'b0, |grant});
      end
    end
  end

  initial begin
    logic [3:0] rq;
    logic       a;
    logic       r;
    rst = 1'b1;
    req = 4'b0000;
    ack = 1'b0;

    // Reset held with active inputs: outputs stay at reset values.
    cyc(1, 4'b1111, 1);
    cyc(1, 4'b1111, 1);
    cyc(1, 4'b0101, 0);

    // Single requester, ack on 3rd grant cycle.
    cyc(0, 4'b0000, 0);
    cyc(0, 4'b0001, 0);
    cyc(0, 4'b0001, 0);
    cyc(0, 4'b0001, 0);
    cyc(0, 4'b0001, 1);
    cyc(0, 4'b0001, 0);
    cyc(0, 4'b0000, 1);
    cyc(0, 4'b0000, 0);

    // Round-robin rotation with all requesting and immediate ack.
    cyc(1, 4'b0000, 0);
    for (int i = 0; i < 16; i++) cyc(0, 4'b1111, 1);

    // Timeout: single holder, never acks.
    cyc(1, 4'b0000, 0);
    for (int i = 0; i < 10; i++) cyc(0, 4'b0100, 0);

    // Ack arriving exactly on the timeout cycle wins.
    cyc(1, 4'b0000, 0);
    for (int i = 0; i < 10; i++) cyc(0, 4'b0100, (m_phase == 1 && m_seen == TO));

    // Request drop mid-grant.
    cyc(1, 4'b0000, 0);
    cyc(0, 4'b0010, 0);
    cyc(0, 4'b0010, 0);
    cyc(0, 4'b0000, 0);
    cyc(0, 4'b0000, 0);
    cyc(0, 4'b0000, 0);

    // Reset mid-grant with last=1, then all request: req[0] first.
    cyc(1, 4'b0000, 0);
    cyc(0, 4'b0010, 0);
    cyc(0, 4'b0010, 1);
    cyc(0, 4'b0000, 0);
    cyc(0, 4'b0100, 0);
    cyc(0, 4'b0100, 0);
    cyc(1, 4'b0100, 0);
    for (int i = 0; i < 4; i++) cyc(0, 4'b1111, 0);

    // Non-granted bits toggling during a grant must not preempt.
    cyc(1, 4'b0000, 0);
    cyc(0, 4'b1000, 0);
    cyc(0, 4'b1111, 0);
    cyc(0, 4'b1001, 0);
    cyc(0, 4'b0000, 0);
    cyc(0, 4'b0000, 0);

    // Randomized traffic.
    rq = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 1) == 0) rq = 4'($urandom);
      a = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 59) == 0);
      cyc(r, rq, a);
    end

    cyc(0, 4'b0000, 0);
    @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
    $finish;
  end

endmodule
